// File: rtl/mcpu_pkg.sv
// mcpu_pkg: MCPU-wide word/address sizes and the memory arbiter state encoding
package mcpu_pkg;
  localparam int WORD_SIZE = 16;
  localparam int ADDR_SIZE = 8;
  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_DM} arb_state_e;
endpackage

// File: rtl/mcpu_mem_arbiter.sv
// mcpu_mem_arbiter: single-port RAM arbiter between instruction fetch and load/store with IF anti-starvation
module mcpu_mem_arbiter #(
  parameter int WORD_SIZE    = mcpu_pkg::WORD_SIZE,
  parameter int ADDR_SIZE    = mcpu_pkg::ADDR_SIZE,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [ADDR_SIZE-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [WORD_SIZE-1:0] if_rdata,
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [ADDR_SIZE-1:0] dm_addr,
  input  logic [WORD_SIZE-1:0] dm_wdata,
  output logic                 dm_gnt,
  output logic                 dm_rvalid,
  output logic [WORD_SIZE-1:0] dm_rdata,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic                 ram_we,
  output logic [WORD_SIZE-1:0] ram_wdata,
  input  logic [WORD_SIZE-1:0] ram_rdata
);
  import mcpu_pkg::*;
  arb_state_e state;
  logic [3:0] starve_cnt;
  logic       idle, starved;
  always_comb begin
    idle      = !reset && state == IDLE;
    starved   = starve_cnt == 4'(STARVE_LIMIT);
    if_gnt    = idle && if_req && (!dm_req || starved);
    dm_gnt    = idle && dm_req && !if_gnt;
    ram_we    = dm_gnt && dm_we;
    ram_addr  = reset ? '0 : dm_gnt ? dm_addr : if_addr;
    ram_wdata = ram_we ? dm_wdata : '0;
    if_rvalid = !reset && state == WAIT_IF;
    dm_rvalid = !reset && state == WAIT_DM;
    if_rdata  = ram_rdata;
    dm_rdata  = ram_rdata;
  end
  // in IDLE with if_req high and no if_gnt, DM necessarily took the slot
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      state      <= if_gnt ? WAIT_IF : (dm_gnt && !dm_we) ? WAIT_DM : IDLE;
      starve_cnt <= (if_gnt || !if_req) ? '0 : starved ? starve_cnt : starve_cnt + 4'd1;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: doc/mcpu_mem_arbiter.md
# mcpu_mem_arbiter

Arbitrates the single-port MCPU RAM between two requesters: the instruction-fetch unit (IF) and the load/store data port (DM, used by OP_LOAD_FROM_MEM / OP_STORE_TO_MEM). It sits between the MCPU control/datapath and `raminst`. It owns all RAM address, write-enable and write-data muxing. It guarantees that IF cannot be starved by back-to-back data traffic.

## Interface
- `WORD_SIZE`, 16, RAM word / instruction width
- `ADDR_SIZE`, 8, RAM address width (256 words)
- `STARVE_LIMIT`, 4, consecutive IF losses after which IF wins the next arbitration (range 1..15)

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request; held until `if_gnt`.
- `if_addr` in ADDR_SIZE: fetch address (PC); stable while `if_req`.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: `if_rdata` valid this cycle.
- `if_rdata` out WORD_SIZE: fetched instruction.
- `dm_req` in 1: data request; held until `dm_gnt`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_addr` in ADDR_SIZE: data address.
- `dm_wdata` in WORD_SIZE: store data.
- `dm_gnt` out 1: data request accepted this cycle.
- `dm_rvalid` out 1: load data valid this cycle.
- `dm_rdata` out WORD_SIZE: load data.
- `ram_addr` out ADDR_SIZE: RAM address.
- `ram_we` out 1: RAM write strobe.
- `ram_wdata` out WORD_SIZE: RAM write data.
- `ram_rdata` in WORD_SIZE: RAM read data, registered, valid the cycle after the address.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - WAIT_IF: IF read in flight.
  - WAIT_DM: DM read in flight.
- IDLE, no request: `ram_we=0`, `ram_addr` = `if_addr`, no grant.
- IDLE, only one requester active: that requester wins.
- IDLE, both active: DM wins, unless `starve_cnt == STARVE_LIMIT`, in which case IF wins.
- On a win:
  - The matching `*_gnt` pulses high for exactly this cycle (combinational from state, reqs and `starve_cnt`).
  - `ram_addr` takes the winner's address.
  - DM store: `ram_we=1`, `ram_wdata=dm_wdata`, stay in IDLE. The store completes in the grant cycle with no rvalid.
  - DM load: go to WAIT_DM.
  - IF fetch: go to WAIT_IF.
- WAIT_IF / WAIT_DM:
  - Assert the matching `*_rvalid` for one cycle; `*_rdata = ram_rdata`.
  - No grant is issued in this cycle; return to IDLE.
- `if_rdata` and `dm_rdata` both pass `ram_rdata` through. Their value is meaningful only while the matching rvalid is high.
- `starve_cnt` (4 bits):
  - Increments when IF requests in IDLE and loses to DM.
  - Clears on `if_gnt`, or when `if_req` is low in IDLE.
  - Saturates at STARVE_LIMIT.
- Requests arriving during WAIT_* are not granted until IDLE. Requesters keep `req` high.
- A requester dropping `req` before its grant is legal. It is simply not served, and its `starve_cnt` contribution clears.

## Timing
- Reset values: state = IDLE, `starve_cnt` = 0.
- While `reset` is high, all outputs are forced:
  - `if_gnt`, `dm_gnt` = 0
  - `if_rvalid`, `dm_rvalid` = 0
  - `ram_we` = 0
  - `ram_addr`, `ram_wdata` = 0
- Read latency: grant in cycle N, rvalid in cycle N+1. Read throughput is 1 per 2 cycles.
- Store latency: the write occurs in the grant cycle. Back-to-back stores run at 1 per cycle.
- Reset asserted during WAIT_*: the in-flight read is dropped and no rvalid is issued. The first cycle after reset deassertion is IDLE.
- Never more than one `*_gnt` or one `*_rvalid` high in any cycle. `ram_we` is high only together with `dm_gnt`.

## Structure
- Shared package `mcpu_pkg` holds:
  - WORD_SIZE and ADDR_SIZE constants, shared with `raminst` and `regfileinst`.
  - The arbiter state enum {IDLE, WAIT_IF, WAIT_DM}.
- Single module, no sub-module. The starvation counter and the output muxes are inline.
- Instantiated inside MCPU as `arbinst`, between the control FSM and `raminst`.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `if_req=dm_req=1` -> no grants, `ram_we=0`. The first cycle after release grants DM.
- **Lone fetch:** `mem[0]={OP_SHORT_TO_REG,R4,8'd40}`, `if_req` with `if_addr=0` -> `if_gnt` in cycle N, `if_rvalid` in N+1 with `if_rdata=16'h?428` (the encoded word).
- **Store then load:**
  - DM store: `addr=100`, `wdata=40` -> `ram_we=1` for one cycle with `ram_addr=100`.
  - Next cycle, DM load from `addr=100` -> `dm_rvalid` with `dm_rdata=40`.
- **Contention:** `if_req` held while DM issues continuous loads; both requesters are active for all arbitrations.
  - DM wins 4 arbitrations, then IF wins the 5th (`starve_cnt=4`).
  - `starve_cnt` returns to 0 after that IF grant.
- **Mid-read reset:** assert `reset` in WAIT_DM -> no `dm_rvalid`, state back to IDLE, `starve_cnt=0`.
- **Back-to-back stores:** 3 DM stores to 101..103 with `if_req=0` -> three consecutive `dm_gnt` cycles. A subsequent readback returns all three values.
